// File: rtl/core_irq_signals.sv
// Shared types and constants for the 6502-class interrupt controller.
// Source encoding and default vectors live here so the top and bench agree.
package core_irq_signals;

  typedef enum logic [1:0] {
    K_NONE,
    K_RESET,
    K_NMI,
    K_IRQ
  } kind_type;

  typedef enum logic [1:0] {
    S_RES_PEND,
    S_IDLE,
    S_SERVICE
  } state_type;

  localparam int CHAN_W = 3;

  localparam logic [15:0] DEF_NMI_VEC  = 16'hFFFA;
  localparam logic [15:0] DEF_RES_VEC  = 16'hFFFC;
  localparam logic [15:0] DEF_IRQ_VEC  = 16'hFFFE;
  localparam logic [15:0] DEF_VEC_BASE = 16'hFFF8;

  localparam logic [3:0] SRC_NONE     = 4'd0;
  localparam logic [3:0] SRC_RESET    = 4'd1;
  localparam logic [3:0] SRC_NMI      = 4'd2;
  localparam logic [3:0] SRC_IRQ_BASE = 4'd3;

  // Per-channel table grows downward two bytes per channel, wrapping at 16 bits.
  function automatic logic [15:0] chan_vec(input logic [15:0] base, input logic [CHAN_W-1:0] chan);
    return base - {12'b0, chan, 1'b0};
  endfunction

endpackage

// File: rtl/core_irq_ctrl_if.sv
// CPU-side request/response bundle of the interrupt controller.
// The core (master) drives the I_* strobes; the controller (slave) drives the O_* results.
interface core_irq_ctrl_if #(
  parameter int CHANNELS = 4
);
  logic                I_enable;
  logic                I_nmi;
  logic [CHANNELS-1:0] I_irq;
  logic                I_irq_mask;
  logic                I_ack;
  logic                O_force_brk;
  logic                O_irq_mask;
  logic [15:0]         O_vec_addr_lo;
  logic [15:0]         O_vec_addr_hi;
  logic [3:0]          O_source;
  logic [CHANNELS-1:0] O_pending;

  modport master (
    output I_enable, I_nmi, I_irq, I_irq_mask, I_ack,
    input  O_force_brk, O_irq_mask, O_vec_addr_lo, O_vec_addr_hi, O_source, O_pending
  );

  modport slave (
    input  I_enable, I_nmi, I_irq, I_irq_mask, I_ack,
    output O_force_brk, O_irq_mask, O_vec_addr_lo, O_vec_addr_hi, O_source, O_pending
  );
endinterface

// File: rtl/core_irq_edge.sv
// Active-low request capture: falling-edge latch with set-over-clear,
// or a plain level pass-through for 6502-style level channels.
module core_irq_edge #(
  parameter bit EDGE = 1'b1
) (
  input  logic I_clock,
  input  logic I_reset,
  input  logic sig_n,
  input  logic clear,
  output logic pending
);

  generate
    if (EDGE) begin : g_edge
      logic hist;
      logic pend;

      // A fresh fall in the same clock as the clear must not be lost.
      always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
          hist <= 1'b1;
          pend <= 1'b0;
        end else begin
          hist <= sig_n;
          if (hist && !sig_n) begin
            pend <= 1'b1;
          end else if (clear) begin
            pend <= 1'b0;
          end
        end
      end

      assign pending = pend;
    end else begin : g_level
      logic unused_edge_inputs;
      assign unused_edge_inputs = ^{I_clock, clear};
      assign pending = ~sig_n & I_reset;
    end
  endgenerate

endmodule

// File: rtl/core_irq_ctrl.sv
// Interrupt controller for the 6502-class core: reset, edge NMI and CHANNELS maskable IRQs,
// sampled at each opcode fetch, with BRK hijack, I-flag force and vector selection.
module core_irq_ctrl
  import core_irq_signals::*;
#(
  parameter int                 CHANNELS  = 4,
  parameter logic [CHANNELS-1:0] EDGE_MASK = '0,
  parameter bit                 VECTORED  = 1'b0,
  parameter logic [15:0]        NMI_VEC   = DEF_NMI_VEC,
  parameter logic [15:0]        RES_VEC   = DEF_RES_VEC,
  parameter logic [15:0]        IRQ_VEC   = DEF_IRQ_VEC,
  parameter logic [15:0]        VEC_BASE  = DEF_VEC_BASE
) (
  input  logic             I_clock,
  input  logic             I_reset,
  core_irq_ctrl_if.slave   bus
);

  state_type           state, next_state;
  kind_type            kind, next_kind, req_kind;
  logic [CHAN_W-1:0]   chan, next_chan, req_chan;
  logic                ack_now;
  logic                nmi_pend;
  logic                nmi_clear;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] irq_clear;

  logic                force_brk;
  logic                irq_mask_out;
  logic [3:0]          source;
  logic [15:0]         vec_lo;

  assign ack_now   = (state == S_SERVICE) && bus.I_ack;
  assign nmi_clear = ack_now && (kind == K_NMI);

  core_irq_edge #(.EDGE(1'b1)) u_nmi (
    .I_clock (I_clock),
    .I_reset (I_reset),
    .sig_n   (bus.I_nmi),
    .clear   (nmi_clear),
    .pending (nmi_pend)
  );

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    assign irq_clear[k] = ack_now && (kind == K_IRQ) && (chan == CHAN_W'(k));

    core_irq_edge #(.EDGE(EDGE_MASK[k])) u_irq (
      .I_clock (I_clock),
      .I_reset (I_reset),
      .sig_n   (bus.I_irq[k]),
      .clear   (irq_clear[k]),
      .pending (pending[k])
    );
  end

  // Walk from the top down so the lowest eligible channel is the one left standing.
  always_comb begin
    req_kind = K_NONE;
    req_chan = '0;
    if (state == S_RES_PEND) begin
      req_kind = K_RESET;
    end else if (nmi_pend) begin
      req_kind = K_NMI;
    end else begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        if (pending[k] && !bus.I_irq_mask) begin
          req_kind = K_IRQ;
          req_chan = CHAN_W'(k);
        end
      end
    end
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state <= S_RES_PEND;
      kind  <= K_NONE;
      chan  <= '0;
    end else begin
      state <= next_state;
      kind  <= next_kind;
      chan  <= next_chan;
    end
  end

  // Enable is ignored while servicing, so an ack in the same clock always wins.
  always_comb begin
    next_state = state;
    next_kind  = kind;
    next_chan  = chan;
    case (state)
      S_RES_PEND, S_IDLE: begin
        if (bus.I_enable && (req_kind != K_NONE)) begin
          next_state = S_SERVICE;
          next_kind  = req_kind;
          next_chan  = req_chan;
        end
      end
      S_SERVICE: begin
        if (bus.I_ack) begin
          next_state = S_IDLE;
          next_kind  = K_NONE;
          next_chan  = '0;
        end
      end
      default: begin
        next_state = S_RES_PEND;
        next_kind  = K_NONE;
        next_chan  = '0;
      end
    endcase
  end

  always_comb begin
    force_brk    = 1'b0;
    irq_mask_out = 1'b0;
    source       = SRC_NONE;
    vec_lo       = IRQ_VEC;
    case (state)
      S_RES_PEND: vec_lo = RES_VEC;
      S_SERVICE: begin
        force_brk    = 1'b1;
        irq_mask_out = 1'b1;
        case (kind)
          K_RESET: begin
            source = SRC_RESET;
            vec_lo = RES_VEC;
          end
          K_NMI: begin
            source = SRC_NMI;
            vec_lo = NMI_VEC;
          end
          K_IRQ: begin
            source = SRC_IRQ_BASE + {1'b0, chan};
            vec_lo = VECTORED ? chan_vec(VEC_BASE, chan) : IRQ_VEC;
          end
          default: begin
            source = SRC_NONE;
            vec_lo = IRQ_VEC;
          end
        endcase
      end
      default: vec_lo = IRQ_VEC;
    endcase
  end

  assign bus.O_force_brk   = force_brk;
  assign bus.O_irq_mask    = irq_mask_out;
  assign bus.O_source      = source;
  assign bus.O_vec_addr_lo = vec_lo;
  assign bus.O_vec_addr_hi = vec_lo + 16'd1;
  assign bus.O_pending     = pending;

endmodule
